// File: rtl/nav_pkg.sv
// nav_pkg: shared types and constants for the navigation menu tree.
// Holds the menu state enum, key bit positions and the output field width.
package nav_pkg;

    typedef enum logic [1:0] {
        ROOT     = 2'd0,
        LOC_MENU = 2'd1,
        ACTIVE   = 2'd2
    } nav_state_e;

    localparam int unsigned KEY_NEXT = 0;
    localparam int unsigned KEY_SEL  = 1;
    localparam int unsigned KEY_PREV = 2;
    localparam int unsigned KEY_BACK = 3;

    localparam int unsigned FIELD_W  = 4;

    // Cursor step forward with wrap inside [0, n-1]; n == 1 pins it at 0.
    function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] cur,
                                                    input logic [FIELD_W-1:0] n);
        return (cur >= n - 4'd1) ? '0 : cur + 4'd1;
    endfunction

    // Cursor step backward with wrap inside [0, n-1]; n == 1 pins it at 0.
    function automatic logic [FIELD_W-1:0] wrap_dec(input logic [FIELD_W-1:0] cur,
                                                    input logic [FIELD_W-1:0] n);
        return (cur == '0) ? n - 4'd1 : cur - 4'd1;
    endfunction

endpackage

// File: rtl/nav_key_event.sv
// nav_key_event: turns the raw button vector into single-shot key events.
// An event fires only when the previous sample was all-released and the
// current sample has exactly one button down; holding a key yields one event.
module nav_key_event
    import nav_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic [3:0]         keys,
    output logic [3:0]         key_evt
);

    logic [3:0] keys_prev_q;
    logic [3:0] keys_prev_d;
    logic       keys_onehot;

    // Edge/one-hot qualification of the current key sample.
    always_comb begin
        keys_prev_d = keys;
        keys_onehot = (keys != '0) && ((keys & (keys - 4'd1)) == '0);
        key_evt     = (keys_prev_q == '0 && keys_onehot) ? keys : '0;
    end

    // Previous-sample register; resets to all-pressed so a key held through
    // reset must be released before it can fire.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            keys_prev_q <= '1;
        end else begin
            keys_prev_q <= keys_prev_d;
        end
    end

endmodule

// File: rtl/nav_menu_tree.sv
// nav_menu_tree: two-level menu navigator (ROOT -> location -> activity).
// Optional idle timeout back to ROOT is enabled by defining NAV_TIMEOUT_EN.
module nav_menu_tree
    import nav_pkg::*;
#(
    parameter int unsigned NUM_LOC        = 2,
    parameter int unsigned NUM_ACT        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [3:0]         keys,
    input  logic               act_done,
    output logic [FIELD_W-1:0] location,
    output logic [FIELD_W-1:0] activity,
    output logic [FIELD_W-1:0] cursor,
    output logic               transition
);

    localparam logic [FIELD_W-1:0] N_LOC = FIELD_W'(NUM_LOC);
    localparam logic [FIELD_W-1:0] N_ACT = FIELD_W'(NUM_ACT);

    logic [3:0]         key_evt;

    nav_state_e         state_q,      state_d;
    logic [FIELD_W-1:0] location_q,   location_d;
    logic [FIELD_W-1:0] activity_q,   activity_d;
    logic [FIELD_W-1:0] cursor_q,     cursor_d;
    logic               transition_q, transition_d;

`ifdef NAV_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
    logic [23:0]        tmo_cnt_q,    tmo_cnt_d;
`endif

    nav_key_event u_key_event (
        .clk     (clk),
        .resetn  (resetn),
        .keys    (keys),
        .key_evt (key_evt)
    );

    // Next-state, field updates, idle timeout and transition pulse.
    always_comb begin
        state_d    = state_q;
        location_d = location_q;
        activity_d = activity_q;
        cursor_d   = cursor_q;

        unique case (state_q)
            ROOT: begin
                if (key_evt[KEY_NEXT]) begin
                    cursor_d = wrap_inc(cursor_q, N_LOC);
                end else if (key_evt[KEY_PREV]) begin
                    cursor_d = wrap_dec(cursor_q, N_LOC);
                end else if (key_evt[KEY_SEL]) begin
                    state_d    = LOC_MENU;
                    location_d = cursor_q + 4'd1;
                    cursor_d   = '0;
                end
            end
            LOC_MENU: begin
                if (key_evt[KEY_NEXT]) begin
                    cursor_d = wrap_inc(cursor_q, N_ACT);
                end else if (key_evt[KEY_PREV]) begin
                    cursor_d = wrap_dec(cursor_q, N_ACT);
                end else if (key_evt[KEY_SEL]) begin
                    state_d    = ACTIVE;
                    activity_d = cursor_q + 4'd1;
                end else if (key_evt[KEY_BACK]) begin
                    state_d    = ROOT;
                    cursor_d   = location_q - 4'd1;
                    location_d = '0;
                end
            end
            ACTIVE: begin
                // back and act_done together still produce a single return
                if (key_evt[KEY_BACK] || act_done) begin
                    state_d    = LOC_MENU;
                    cursor_d   = activity_q - 4'd1;
                    activity_d = '0;
                end
            end
            default: begin
                state_d = ROOT;
            end
        endcase

`ifdef NAV_TIMEOUT_EN
        // Counter only advances on idle cycles that stay inside a menu level;
        // the timeout is applied only when no regular move happened this cycle.
        tmo_cnt_d = '0;
        if (state_q != ROOT && state_d == state_q && key_evt == '0) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d    = ROOT;
                location_d = '0;
                activity_d = '0;
                cursor_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 24'd1;
            end
        end
`endif

        transition_d = (location_d != location_q) || (activity_d != activity_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ROOT;
            location_q   <= '0;
            activity_q   <= '0;
            cursor_q     <= '0;
            transition_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            location_q   <= location_d;
            activity_q   <= activity_d;
            cursor_q     <= cursor_d;
            transition_q <= transition_d;
        end
    end

`ifdef NAV_TIMEOUT_EN
    // Idle timeout counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign location   = location_q;
    assign activity   = activity_q;
    assign cursor     = cursor_q;
    assign transition = transition_q;

endmodule

// File: tb/tb_nav_menu_tree.sv
// tb_nav_menu_tree: scoreboard bench for nav_menu_tree (NUM_LOC=3, NUM_ACT=2,
// TIMEOUT_CYCLES=16). Honours NAV_TIMEOUT_EN in its reference model.
module tb_nav_menu_tree;

    localparam int NL = 3;
    localparam int NA = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] keys = 4'h0;
    logic       act_done = 1'b0;
    logic [3:0] location, activity, cursor;
    logic       transition;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int loc;
        int act;
        int cur;
        int tr;
    } exp_t;

    exp_t exp_q[$];

    // reference model state: the menu position as plain integers
    int m_loc = 0, m_act = 0, m_cur = 0, m_idle = 0;
    logic [3:0] m_prev = 4'hF;

    always #5 clk = ~clk;

    nav_menu_tree #(
        .NUM_LOC        (NL),
        .NUM_ACT        (NA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .keys       (keys),
        .act_done   (act_done),
        .location   (location),
        .activity   (activity),
        .cursor     (cursor),
        .transition (transition)
    );

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
        end
    endtask

    // Behavioural rule set: one cycle of the menu given inputs sampled that cycle.
    task automatic model_step(input logic [3:0] k, input logic ad, output int tr);
        int ev;
        int old_loc, old_act;
        bit changed;
        ev = (m_prev == 4'h0 && $onehot(k)) ? int'(k) : 0;
        m_prev  = k;
        old_loc = m_loc;
        old_act = m_act;
        if (m_loc == 0) begin
            if (ev == 1)      m_cur = (m_cur + 1) % NL;
            else if (ev == 4) m_cur = (m_cur + NL - 1) % NL;
            else if (ev == 2) begin m_loc = m_cur + 1; m_cur = 0; end
        end else if (m_act == 0) begin
            if (ev == 1)      m_cur = (m_cur + 1) % NA;
            else if (ev == 4) m_cur = (m_cur + NA - 1) % NA;
            else if (ev == 2) m_act = m_cur + 1;
            else if (ev == 8) begin m_cur = m_loc - 1; m_loc = 0; end
        end else if (ev == 8 || ad) begin
            m_cur = m_act - 1;
            m_act = 0;
        end
        changed = (old_loc != m_loc) || (old_act != m_act);
`ifdef NAV_TIMEOUT_EN
        if (old_loc == 0 || changed || ev != 0) begin
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                m_loc = 0; m_act = 0; m_cur = 0; m_idle = 0;
                changed = 1'b1;
            end
        end
`endif
        tr = changed ? 1 : 0;
    endtask

    // Drive one cycle of inputs and queue the response expected after the edge.
    task automatic cyc(input logic [3:0] k, input logic ad, input logic rn);
        exp_t e;
        int tr;
        @(negedge clk);
        keys     = k;
        act_done = ad;
        resetn   = rn;
        if (!rn) begin
            m_loc = 0; m_act = 0; m_cur = 0; m_idle = 0; m_prev = 4'hF;
            tr = 0;
        end else begin
            model_step(k, ad, tr);
        end
        e.loc = m_loc; e.act = m_act; e.cur = m_cur; e.tr = tr;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] k);
        cyc(k, 1'b0, 1'b1);
        cyc(4'h0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'h0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are registered, so compare every cycle just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("location",   int'(location),   e.loc);
            check("activity",   int'(activity),   e.act);
            check("cursor",     int'(cursor),     e.cur);
            check("transition", int'(transition), e.tr);
        end
    end

    initial begin
        int r;
        logic [3:0] k;
        logic ad;

        // reset state
        for (int i = 0; i < 3; i++) cyc(4'h0, 1'b0, 1'b0);
        idle(2);

        // next x3 with wrap, then position cursor at 2 and select location 3
        press(4'h1); press(4'h1); press(4'h1);
        press(4'h1); press(4'h1);
        for (int i = 0; i < 11; i++) cyc(4'h2, 1'b0, 1'b1);
        cyc(4'h0, 1'b0, 1'b1);

        // prev wraps to 1, select activity 2, back with act_done returns once
        press(4'h4);
        press(4'h2);
        cyc(4'h8, 1'b1, 1'b1);
        idle(2);

        // two-hot pattern is not an event; then a clean next
        cyc(4'h5, 1'b0, 1'b1);
        cyc(4'h0, 1'b0, 1'b1);
        press(4'h1);

        // key held through reset release fires nothing until re-pressed
        cyc(4'h1, 1'b0, 1'b0);
        cyc(4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(4'h1, 1'b0, 1'b1);
        cyc(4'h0, 1'b0, 1'b1);
        press(4'h1);

        // act_done outside ACTIVE is ignored
        cyc(4'h0, 1'b1, 1'b1);
        idle(1);

        // enter ACTIVE and sit idle a long time
        press(4'h2);
        press(4'h2);
        idle(1000);

        // reset in the middle of an activity
        press(4'h2);
        press(4'h2);
        idle(3);
        cyc(4'h0, 1'b0, 1'b0);
        idle(3);

        // randomized traffic with held keys, idle stretches and rare resets
        k = 4'h0;
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      k = 4'h0;
            else if (r < 70) k = 4'h1 << $urandom_range(0, 3);
            else if (r < 78) k = 4'($urandom_range(0, 15));
            // otherwise hold previous keys
            ad = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                cyc(k, ad, 1'b0);
            end else if ($urandom_range(0, 39) == 0) begin
                idle($urandom_range(10, 25));
            end else begin
                cyc(k, ad, 1'b1);
            end
        end
        idle(2);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nav_menu_tree.md
NAV_MENU_TREE -- requirements
Module: nav_menu_tree

Interface
- REQ-001 Parameter NUM_LOC, default 2: number of locations (1..15).
- REQ-002 Parameter NUM_ACT, default 2: number of activities per location (1..15).
- REQ-003 Parameter TIMEOUT_CYCLES, default 1000: idle cycles before auto-return to ROOT (1..2^24-1).
- REQ-004 clk  input  1: single clock, rising edge.
- REQ-005 resetn  input  1: asynchronous, active-low reset.
- REQ-006 keys  input  4: buttons {back, prev, select, next}, active-high, synchronous to clk.
- REQ-007 act_done  input  1: one-cycle pulse; the running activity has finished.
- REQ-008 location  output  4: 0 = ROOT, else 1..NUM_LOC.
- REQ-009 activity  output  4: 0 = none, else 1..NUM_ACT.
- REQ-010 cursor  output  4: highlighted menu entry, 0-based.
- REQ-011 transition  output  1: one-cycle pulse on any change of location or activity.

Function
- REQ-012 Key event: keys_prev == 4'h0 and keys is one-hot; all other patterns produce no event.
- REQ-013 A held key generates exactly one event; release to 4'h0 is required before the next event.
- REQ-014 States: ROOT, LOC_MENU, ACTIVE; registered; outputs are driven from registers only.
- REQ-015 ROOT: next/prev move cursor modulo NUM_LOC with wrap (NUM_LOC-1 -> 0, 0 -> NUM_LOC-1); back is a no-op.
- REQ-016 ROOT, select: go to LOC_MENU, location = cursor+1, cursor = 0.
- REQ-017 LOC_MENU: next/prev move cursor modulo NUM_ACT with wrap.
- REQ-018 LOC_MENU, select: go to ACTIVE, activity = cursor+1.
- REQ-019 LOC_MENU, back: go to ROOT, cursor = location-1, location = 0.
- REQ-020 ACTIVE: next/prev/select are ignored.
- REQ-021 ACTIVE, back event or act_done: go to LOC_MENU, cursor = activity-1, activity = 0.
- REQ-022 back and act_done in the same cycle cause one return only.
- REQ-023 act_done outside ACTIVE is ignored.
- REQ-024 All updates take effect at the clk edge following the event cycle (latency 1).
- REQ-025 transition is high in exactly the first cycle the new location/activity is visible.
- REQ-026 transition stays low for cursor-only changes.
- REQ-027 With NUM_LOC=1 or NUM_ACT=1, next/prev leave cursor at 0.

Reset
- REQ-028 On resetn low: state = ROOT; location, activity, cursor = 0; transition = 0; timeout counter = 0.
- REQ-029 On resetn low: keys_prev = 4'hF, so a key held through reset fires no event until released.
- REQ-030 Reset asserted mid-activity aborts immediately to ROOT, with no transition pulse on deassertion.

Configuration
- REQ-031 With NAV_TIMEOUT_EN defined: in LOC_MENU or ACTIVE, TIMEOUT_CYCLES consecutive cycles without a key event cause a jump to ROOT.
- REQ-032 On that timeout: location, activity, cursor = 0, and transition pulses.
- REQ-033 The timeout counter clears on any key event or state change, and holds at 0 in ROOT.
- REQ-034 Without NAV_TIMEOUT_EN: no counter logic exists and the state persists indefinitely.

Structure
- REQ-035 Package nav_pkg holds: state enum (ROOT, LOC_MENU, ACTIVE), key bit-index constants (KEY_NEXT=0, KEY_SEL=1, KEY_PREV=2, KEY_BACK=3), and the 4-bit field width constant.
- REQ-036 Sub-module nav_key_event holds keys_prev and the one-hot/edge detection, and outputs a 4-bit one-hot event vector.

Verification (NUM_LOC=3, NUM_ACT=2, TIMEOUT_CYCLES=16)
- REQ-037 Reset, then next x3 -> cursor 1, 2, 0 (wrap); location stays 0; transition stays 0.
- REQ-038 cursor=2, select -> next cycle: location=3, cursor=0, one transition pulse; holding select 10 cycles -> no further change.
- REQ-039 LOC_MENU, prev -> cursor=1; select -> activity=2; act_done together with back -> activity=0, cursor=1, single transition pulse.
- REQ-040 keys=4'b0101 pressed from release -> no event; then release and next -> one cursor step.
- REQ-041 Key held while resetn deasserts -> no event until release and re-press.
- REQ-042 With NAV_TIMEOUT_EN, ACTIVE idle 16 cycles -> location=0, activity=0, transition pulse; without the macro, 1000 idle cycles -> no change.
